dram_req_arbiter: RTL and testbench
===================================

// Module: dram_req_arbiter
// PURPOSE
//  Shares the single DRAM slave port between NUM_REQ requesters (e.g. DMA, data-cache refill).
//  Round-robin arbitration; one transaction in flight at a time. Issues it on the AR or AW channel,
//  then holds ownership until the read burst's last beat or the write response completes.
//  Watchdog releases a hung transaction. W/R/B data are muxed externally by the one-hot owner output.
// PARAMETERS
//  NUM_REQ  2     number of requesters (2..4)
//  ADDR_W   32    address width (= `AXI_ADDR_BITS)
//  LEN_W    4     burst length width (= `AXI_LEN_BITS)
//  ID_W     8     issued ID width (= `AXI_IDS_BITS)
//  TIMEOUT  1023  cycles from address issue to forced release; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1               clock, all logic on posedge
//  rst        in   1               asynchronous active-low reset
//  req_valid  in   NUM_REQ         per-requester request pending; held until req_ready
//  req_write  in   NUM_REQ         1 = write burst, 0 = read burst
//  req_addr   in   NUM_REQ*ADDR_W  packed start addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_len    in   NUM_REQ*LEN_W   packed burst lengths (beats-1)
//  req_ready  out  NUM_REQ         one-hot accept, combinational, IDLE only
//  req_done   out  NUM_REQ         one-hot 1-cycle pulse: transaction completed
//  req_err    out  NUM_REQ         one-hot 1-cycle pulse: transaction aborted by watchdog
//  owner      out  NUM_REQ         one-hot current owner, 0 in IDLE
//  busy       out  1               1 whenever state != IDLE
//  m_arvalid/m_awvalid  out  1     address valid to DRAM slave
//  m_arready/m_awready  in   1     address ready from DRAM slave
//  m_axaddr   out  ADDR_W          latched address (shared by AR/AW)
//  m_axlen    out  LEN_W           latched length
//  m_axid     out  ID_W            zero-extended granted requester index
//  m_rvalid, m_rready, m_rlast  in  1  snooped read-data handshake
//  m_bvalid, m_bready           in  1  snooped write-response handshake
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = 0; watchdog = 0. Reset mid-transaction aborts locally only.
//  FSM: IDLE -> ADDR -> WAIT_R | WAIT_B -> IDLE.
//   IDLE: g = first i with req_valid[i], searching i = ptr, ptr+1, ... mod NUM_REQ.
//         Same cycle: req_ready[g]=1. Latch addr/len/write/g. Next state ADDR. No valid: stay.
//   ADDR: m_arvalid (read) or m_awvalid (write) = 1; addr/len/id stable until ready.
//         On m_arready -> WAIT_R; on m_awready -> WAIT_B.
//   WAIT_R: completes on m_rvalid & m_rready & m_rlast.
//   WAIT_B: completes on m_bvalid & m_bready.
//  Completion: next cycle IDLE, req_done[g] = 1 for that cycle (registered), ptr = (g+1) mod NUM_REQ.
//   A new grant may occur in that same IDLE cycle.
//  Latency: req_valid seen in IDLE cycle t -> req_ready at t, m_axvalid at t+1.
//  owner = one-hot(g) in ADDR/WAIT_*, 0 in IDLE.
//  Watchdog: cleared on entering ADDR; increments every cycle in ADDR/WAIT_*.
//   On reaching TIMEOUT: next cycle IDLE with req_err[g]=1 and ptr advanced as for completion; no req_done.
//  Completion and timeout in the same cycle: completion wins (req_done only).
//  Only one of req_done/req_err/req_ready-of-same-requester is high per cycle for a given transaction.
//  Fairness: all requesters continuously valid -> grants rotate 0,1,..,NUM_REQ-1,0.
//  req_valid dropping before req_ready is a requester protocol error; arbitration re-evaluates each IDLE cycle.
// TESTING
//  Reset: hold rst=0 with random inputs -> all outputs 0. Release; req_valid=0 -> busy stays 0.
//  Read req0 addr 0x0000_2010 len 3 -> req_ready[0] at t; m_arvalid, addr 0x0000_2010, len 3, id 0 at t+1;
//   4 R beats, last with m_rlast -> req_done[0] pulse next cycle, busy=0.
//  Write req1 addr 0x0000_3000 len 0, m_awready low 5 cycles -> m_awvalid and fields stable 5 cycles;
//   then B handshake -> req_done[1].
//  req0 and req1 both valid for 6 reads -> grant order 0,1,0,1,0,1; owner one-hot matches each grant.
//  TIMEOUT=16, read accepted but no m_rlast -> req_err[0] 16 cycles after ADDR entry; no req_done;
//   pending req1 granted next.
//  RLAST handshake on the cycle watchdog hits TIMEOUT -> req_done only. Reset asserted in WAIT_R -> IDLE, outputs 0.

Source files
------------

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter
//   Shares one DRAM slave port among NUM_REQ requesters using round-robin
//   arbitration. Only one transaction is in flight at a time. The arbiter
//   issues the address on AR or AW, then keeps ownership until the read
//   burst's last beat or the write response. A watchdog releases the port
//   if a transaction hangs. W/R/B data are steered outside this block by the
//   one-hot owner output.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/write/addr/len per-requester request (addr/len packed by index)
//   req_ready                one-hot accept, combinational, IDLE only
//   req_done / req_err       one-hot single-cycle completion / watchdog abort
//   owner, busy              current owner (one-hot), transaction in progress
//   m_arvalid/m_awvalid      address valid toward the slave
//   m_arready/m_awready      address ready from the slave
//   m_axaddr/m_axlen/m_axid  latched address, length and requester index
//   m_rvalid/m_rready/m_rlast, m_bvalid/m_bready  snooped completion handshakes
module dram_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 4,
    parameter int ID_W    = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [NUM_REQ-1:0]        owner,
    output logic                      busy,
    output logic                      m_arvalid,
    output logic                      m_awvalid,
    input  logic                      m_arready,
    input  logic                      m_awready,
    output logic [ADDR_W-1:0]         m_axaddr,
    output logic [LEN_W-1:0]          m_axlen,
    output logic [ID_W-1:0]           m_axid,
    input  logic                      m_rvalid,
    input  logic                      m_rready,
    input  logic                      m_rlast,
    input  logic                      m_bvalid,
    input  logic                      m_bready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT_R,
        ST_WAIT_B
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0]  lat_addr;
    logic [LEN_W-1:0]   lat_len;
    logic               lat_write;
    logic [CNT_W-1:0]   wdog;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     cand;
    logic               accept;
    logic               finish_ok;
    logic               finish_to;
    logic               timeout_hit;
    logic [IDX_W-1:0]   ptr_after;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Round-robin search: first valid requester starting at ptr, wrapping
    // modulo NUM_REQ (which need not be a power of two).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // After a transaction ends, priority moves to the requester just past
    // the one that was served.
    assign ptr_after = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // The watchdog fires on the cycle its count steps up to TIMEOUT, so the
    // port is released exactly TIMEOUT cycles after ADDR was entered.
    // A completion handshake in that same cycle takes precedence.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        finish_ok   = 1'b0;
        finish_to   = 1'b0;
        timeout_hit = (state != ST_IDLE) && (wdog == CNT_W'(TIMEOUT - 1));
        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (timeout_hit) begin
                    finish_to  = 1'b1;
                    state_next = ST_IDLE;
                end else if (!lat_write && m_arready) begin
                    state_next = ST_WAIT_R;
                end else if (lat_write && m_awready) begin
                    state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_R: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    finish_ok  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    finish_to  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_B: begin
                if (m_bvalid && m_bready) begin
                    finish_ok  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    finish_to  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, latched request fields, watchdog, rotation pointer and the
    // registered done/error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            lat_addr  <= '0;
            lat_len   <= '0;
            lat_write <= 1'b0;
            wdog      <= '0;
            req_done  <= '0;
            req_err   <= '0;
        end else begin
            state    <= state_next;
            req_done <= finish_ok ? onehot(gnt_idx) : '0;
            req_err  <= finish_to ? onehot(gnt_idx) : '0;
            if (accept) begin
                gnt_idx   <= grant_idx;
                lat_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                lat_len   <= req_len[grant_idx*LEN_W +: LEN_W];
                lat_write <= req_write[grant_idx];
                wdog      <= '0;
            end else if (state != ST_IDLE) begin
                wdog <= wdog + CNT_W'(1);
            end
            if (finish_ok || finish_to) begin
                ptr <= ptr_after;
            end
        end
    end

    // req_ready is gated by reset so nothing is accepted while held in reset.
    assign req_ready = (accept && rst) ? onehot(grant_idx) : '0;
    assign busy      = (state != ST_IDLE);
    assign owner     = busy ? onehot(gnt_idx) : '0;
    assign m_arvalid = (state == ST_ADDR) && !lat_write;
    assign m_awvalid = (state == ST_ADDR) && lat_write;
    assign m_axaddr  = lat_addr;
    assign m_axlen   = lat_len;
    assign m_axid    = ID_W'(gnt_idx);

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter
//   Directed bench for dram_req_arbiter with two requesters and a short
//   watchdog. Inputs change just after the falling edge; outputs are sampled
//   1 time unit later, well away from the rising edge.
module tb_dram_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int ID_W    = 8;
    localparam int TIMEOUT = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic [NUM_REQ-1:0]        owner;
    logic                      busy;
    logic                      m_arvalid;
    logic                      m_awvalid;
    logic                      m_arready;
    logic                      m_awready;
    logic [ADDR_W-1:0]         m_axaddr;
    logic [LEN_W-1:0]          m_axlen;
    logic [ID_W-1:0]           m_axid;
    logic                      m_rvalid;
    logic                      m_rready;
    logic                      m_rlast;
    logic                      m_bvalid;
    logic                      m_bready;

    int error_count;
    int check_count;

    dram_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .req_done  (req_done),
        .req_err   (req_err),
        .owner     (owner),
        .busy      (busy),
        .m_arvalid (m_arvalid),
        .m_awvalid (m_awvalid),
        .m_arready (m_arready),
        .m_awready (m_awready),
        .m_axaddr  (m_axaddr),
        .m_axlen   (m_axlen),
        .m_axid    (m_axid),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rlast   (m_rlast),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] write);
        req_valid = valid;
        req_write = write;
    endtask

    task automatic clearBus();
        m_arready = 1'b0;
        m_awready = 1'b0;
        m_rvalid  = 1'b0;
        m_rready  = 1'b0;
        m_rlast   = 1'b0;
        m_bvalid  = 1'b0;
        m_bready  = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        int exp_g;
        error_count = 0;
        check_count = 0;
        rst = 1'b0;
        applyStimulus(2'b00, 2'b00);
        req_addr = '0;
        req_len  = '0;
        clearBus();

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            req_addr  = {$urandom, $urandom};
            req_len   = 8'($urandom);
            m_arready = 1'($urandom);
            m_awready = 1'($urandom);
            m_rvalid  = 1'($urandom);
            m_rready  = 1'($urandom);
            m_rlast   = 1'($urandom);
            m_bvalid  = 1'($urandom);
            m_bready  = 1'($urandom);
            #1;
            checkOutput("rst_ready", 64'(req_ready), 64'd0);
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_owner", 64'(owner), 64'd0);
            checkOutput("rst_axvalid", 64'({m_arvalid, m_awvalid}), 64'd0);
            checkOutput("rst_pulses", 64'({req_done, req_err}), 64'd0);
            checkOutput("rst_ax", 64'({m_axaddr, m_axlen, m_axid}), 64'd0);
        end

        // Release with no requests: stays idle.
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        clearBus();
        req_addr = '0;
        req_len  = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            #1;
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_ready", 64'(req_ready), 64'd0);
        end

        // Read from requester 0, 4 beats.
        nextCycle();
        req_addr[31:0] = 32'h0000_2010;
        req_len[3:0]   = 4'd3;
        applyStimulus(2'b01, 2'b00);
        #1;
        checkOutput("rd0_ready", 64'(req_ready), 64'(2'b01));
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        m_arready = 1'b1;
        #1;
        checkOutput("rd0_arvalid", 64'({m_arvalid, m_awvalid}), 64'(2'b10));
        checkOutput("rd0_addr", 64'(m_axaddr), 64'h0000_2010);
        checkOutput("rd0_len", 64'(m_axlen), 64'd3);
        checkOutput("rd0_id", 64'(m_axid), 64'd0);
        checkOutput("rd0_owner", 64'(owner), 64'(2'b01));
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rready  = 1'b1;
            m_rlast   = (b == 3);
            #1;
            checkOutput("rd0_beat_busy", 64'({busy, req_done, m_arvalid}), 64'(4'b1000));
        end
        nextCycle();
        clearBus();
        #1;
        checkOutput("rd0_done", 64'(req_done), 64'(2'b01));
        checkOutput("rd0_idle", 64'({busy, owner}), 64'd0);
        nextCycle();
        #1;
        checkOutput("rd0_done_pulse", 64'(req_done), 64'd0);

        // Write from requester 1, address stalled for 5 cycles.
        req_addr[63:32] = 32'h0000_3000;
        req_len[7:4]    = 4'd0;
        applyStimulus(2'b10, 2'b10);
        #1;
        checkOutput("wr1_ready", 64'(req_ready), 64'(2'b10));
        for (int s = 0; s < 6; s++) begin
            nextCycle();
            applyStimulus(2'b00, 2'b00);
            m_awready = (s == 5);
            #1;
            checkOutput("wr1_awvalid", 64'({m_arvalid, m_awvalid}), 64'(2'b01));
            checkOutput("wr1_fields", 64'({m_axaddr, m_axlen, m_axid}), {20'd0, 32'h0000_3000, 4'd0, 8'd1});
            checkOutput("wr1_owner", 64'(owner), 64'(2'b10));
        end
        nextCycle();
        m_awready = 1'b0;
        m_bvalid  = 1'b1;
        m_bready  = 1'b0;
        #1;
        checkOutput("wr1_waitb", 64'({busy, m_awvalid, req_done}), 64'(4'b1000));
        nextCycle();
        m_bready = 1'b1;
        #1;
        checkOutput("wr1_bhs_busy", 64'(busy), 64'd1);
        nextCycle();
        clearBus();
        #1;
        checkOutput("wr1_done", 64'(req_done), 64'(2'b10));
        checkOutput("wr1_busy", 64'(busy), 64'd0);

        // Both requesters always valid: grants alternate 0,1,0,1,0,1.
        req_addr = {32'h0000_1100, 32'h0000_1000};
        req_len  = '0;
        nextCycle();
        for (int n = 0; n < 6; n++) begin
            exp_g = n % 2;
            applyStimulus(2'b11, 2'b00);
            clearBus();
            #1;
            checkOutput("rr_ready", 64'(req_ready), 64'(oh(exp_g)));
            if (n > 0) begin
                checkOutput("rr_done", 64'(req_done), 64'(oh(1 - exp_g)));
            end
            nextCycle();
            m_arready = 1'b1;
            #1;
            checkOutput("rr_owner", 64'(owner), 64'(oh(exp_g)));
            checkOutput("rr_id", 64'(m_axid), 64'(exp_g));
            checkOutput("rr_addr", 64'(m_axaddr), (exp_g == 0) ? 64'h1000 : 64'h1100);
            nextCycle();
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rready  = 1'b1;
            m_rlast   = 1'b1;
            nextCycle();
        end
        applyStimulus(2'b00, 2'b00);
        clearBus();
        #1;
        checkOutput("rr_last_done", 64'(req_done), 64'(2'b10));
        checkOutput("rr_no_grant", 64'(req_ready), 64'd0);

        // Watchdog: requester 0 read never completes; requester 1 waits.
        nextCycle();
        applyStimulus(2'b11, 2'b00);
        #1;
        checkOutput("to_ready", 64'(req_ready), 64'(2'b01));
        nextCycle();
        applyStimulus(2'b10, 2'b00);
        m_arready = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k > 0) begin
                nextCycle();
                m_arready = 1'b0;
            end
            #1;
            checkOutput("to_wait", 64'({busy, req_err, req_done}), 64'(5'b10000));
        end
        nextCycle();
        #1;
        checkOutput("to_err", 64'(req_err), 64'(2'b01));
        checkOutput("to_no_done", 64'(req_done), 64'd0);
        checkOutput("to_next_grant", 64'(req_ready), 64'(2'b10));
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        m_arready = 1'b1;
        #1;
        checkOutput("to_req1_owner", 64'({owner, req_err}), 64'(4'b1000));
        nextCycle();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rready  = 1'b1;
        m_rlast   = 1'b1;
        nextCycle();
        clearBus();
        #1;
        checkOutput("to_req1_done", 64'(req_done), 64'(2'b10));

        // Last beat arrives on the very cycle the watchdog expires.
        nextCycle();
        applyStimulus(2'b01, 2'b00);
        #1;
        checkOutput("race_ready", 64'(req_ready), 64'(2'b01));
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        m_arready = 1'b1;
        for (int k = 1; k < TIMEOUT; k++) begin
            nextCycle();
            m_arready = 1'b0;
            if (k == TIMEOUT - 1) begin
                m_rvalid = 1'b1;
                m_rready = 1'b1;
                m_rlast  = 1'b1;
            end
        end
        #1;
        checkOutput("race_busy", 64'(busy), 64'd1);
        nextCycle();
        clearBus();
        #1;
        checkOutput("race_done", 64'(req_done), 64'(2'b01));
        checkOutput("race_no_err", 64'(req_err), 64'd0);
        nextCycle();
        #1;
        checkOutput("race_no_err_late", 64'(req_err), 64'd0);

        // Reset asserted in WAIT_R aborts locally and restores the pointer.
        applyStimulus(2'b10, 2'b00);
        #1;
        checkOutput("rstmid_ready", 64'(req_ready), 64'(2'b10));
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        m_arready = 1'b1;
        nextCycle();
        m_arready = 1'b0;
        #1;
        checkOutput("rstmid_waitr", 64'({busy, owner}), 64'(3'b110));
        nextCycle();
        applyStimulus(2'b11, 2'b00);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_busy", 64'({busy, owner, req_ready}), 64'd0);
        checkOutput("rstmid_ax", 64'({m_arvalid, m_awvalid, m_axaddr, m_axid}), 64'd0);
        checkOutput("rstmid_pulses", 64'({req_done, req_err}), 64'd0);
        nextCycle();
        applyStimulus(2'b00, 2'b00);
        rst = 1'b1;
        nextCycle();
        #1;
        checkOutput("rstmid_idle", 64'(busy), 64'd0);
        applyStimulus(2'b11, 2'b00);
        #1;
        checkOutput("rstmid_ptr", 64'(req_ready), 64'(2'b01));
        nextCycle();
        applyStimulus(2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
